// File: rtl/key_pkg.sv
// Shared definitions for the multi-key front end: counter mode encodings and a
// constant-width helper used to size the debounce and hold counters.
package key_pkg;

    localparam int MODE_PRESS_CNT  = 0;
    localparam int MODE_SHORT_LONG = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce, hold timing, event pulses and
// a wrapping per-key counter. Input is already normalised so 1 means pressed.
module key_chan
    import key_pkg::*;
#(
    parameter int DEB_CYCLES  = 20000,
    parameter int LONG_CYCLES = 1500000,
    parameter int CNT_W       = 2,
    parameter int MODE        = MODE_PRESS_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pressed,
    input  logic             cnt_clr,
    output logic             key_down,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             short_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] cnt
);

    localparam int DEB_W  = clog2(DEB_CYCLES);
    localparam int HOLD_W = clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              sync1;
    logic              sync2;
    logic [DEB_W-1:0]  deb_cnt;
    logic              down_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_flag;
    logic              rise;
    logic              fall;
    logic              long_hit;

    // Edges are taken against the previous debounced level, so every pulse
    // and counter update lands one cycle after key_down changes.
    assign rise     = key_down & ~down_q;
    assign fall     = ~key_down & down_q;
    assign long_hit = key_down & down_q & (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            deb_cnt       <= '0;
            key_down      <= 1'b0;
            down_q        <= 1'b0;
            hold_cnt      <= '0;
            long_flag     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            cnt           <= '0;
        end else begin
            sync1 <= pressed;
            sync2 <= sync1;

            if (sync2 != key_down) begin
                if (deb_cnt == DEB_MAX) begin
                    key_down <= ~key_down;
                    deb_cnt  <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end

            down_q        <= key_down;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_pulse   <= fall & ~long_flag;
            long_pulse    <= long_hit;

            // Hold counter saturates so long_pulse fires only once per hold.
            if (rise) begin
                hold_cnt <= '0;
            end else if (key_down) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end

            if (long_hit) begin
                long_flag <= 1'b1;
            end else if (fall) begin
                long_flag <= 1'b0;
            end

            if (cnt_clr) begin
                cnt <= '0;
            end else if (MODE == MODE_PRESS_CNT) begin
                if (rise) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (fall && !long_flag) begin
                    cnt <= cnt + 1'b1;
                end else if (long_hit) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/key_multi_ctl.sv
// Multi-key front end: normalises pin polarity and fans the key bus out to one
// key_chan per key, packing each channel's counter into the cnt bus.
module key_multi_ctl
    import key_pkg::*;
#(
    parameter int KEY_NUM     = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int DEB_CYCLES  = 20000,
    parameter int LONG_CYCLES = 1500000,
    parameter int CNT_W       = 2,
    parameter int MODE        = MODE_PRESS_CNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KEY_NUM-1:0]       key,
    input  logic [KEY_NUM-1:0]       cnt_clr,
    output logic [KEY_NUM-1:0]       key_down,
    output logic [KEY_NUM-1:0]       press_pulse,
    output logic [KEY_NUM-1:0]       release_pulse,
    output logic [KEY_NUM-1:0]       short_pulse,
    output logic [KEY_NUM-1:0]       long_pulse,
    output logic [KEY_NUM*CNT_W-1:0] cnt
);

    logic [KEY_NUM-1:0] pressed;

    assign pressed = (ACTIVE_LOW != 0) ? ~key : key;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
        key_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .CNT_W      (CNT_W),
            .MODE       (MODE)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .pressed      (pressed[i]),
            .cnt_clr      (cnt_clr[i]),
            .key_down     (key_down[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .short_pulse  (short_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .cnt          (cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_key_multi_ctl.sv
// Scoreboard bench for key_multi_ctl: three instances (MODE 0 active-low, MODE 1
// active-low, MODE 0 active-high); expected pulses are queued, a monitor pops them.
module tb_key_multi_ctl;

    typedef struct {
        int d;
        int k;
        int kind;
        int cyc;
        int cv;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pin  [3];
    logic [1:0] clr  [3];
    logic [1:0] kd   [3];
    logic [1:0] pp   [3];
    logic [1:0] rp   [3];
    logic [1:0] sp   [3];
    logic [1:0] lp   [3];
    logic [3:0] cv   [3];

    int  cyc = 0;
    int  checks_total = 0;
    int  checks_passed = 0;
    int  mdl [3][2];
    ev_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_multi_ctl #(.KEY_NUM(2), .ACTIVE_LOW(1), .DEB_CYCLES(4), .LONG_CYCLES(20), .CNT_W(2), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .key(pin[0]), .cnt_clr(clr[0]), .key_down(kd[0]),
        .press_pulse(pp[0]), .release_pulse(rp[0]), .short_pulse(sp[0]), .long_pulse(lp[0]), .cnt(cv[0]));

    key_multi_ctl #(.KEY_NUM(2), .ACTIVE_LOW(1), .DEB_CYCLES(4), .LONG_CYCLES(20), .CNT_W(2), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .key(pin[1]), .cnt_clr(clr[1]), .key_down(kd[1]),
        .press_pulse(pp[1]), .release_pulse(rp[1]), .short_pulse(sp[1]), .long_pulse(lp[1]), .cnt(cv[1]));

    key_multi_ctl #(.KEY_NUM(2), .ACTIVE_LOW(0), .DEB_CYCLES(4), .LONG_CYCLES(20), .CNT_W(2), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .key(pin[2]), .cnt_clr(clr[2]), .key_down(kd[2]),
        .press_pulse(pp[2]), .release_pulse(rp[2]), .short_pulse(sp[2]), .long_pulse(lp[2]), .cnt(cv[2]));

    function automatic logic pulseBit(input int d, input int k, input int kind);
        logic b;
        case (kind)
            0:       b = pp[d][k];
            1:       b = rp[d][k];
            2:       b = sp[d][k];
            default: b = lp[d][k];
        endcase
        return b;
    endfunction

    // Scan order (instance, key, press/release/short/long) matches push order.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 2; k++) begin
                for (int kind = 0; kind < 4; kind++) begin
                    if (pulseBit(d, k, kind)) begin
                        int act_cv;
                        act_cv = int'(cv[d][k*2 +: 2]);
                        checks_total++;
                        if (exp_q.size() == 0) begin
                            $display("[TB] FAIL unexpected_pulse d%0d k%0d kind%0d at cyc %0d, required none", d, k, kind, cyc);
                        end else begin
                            ev_t e;
                            e = exp_q.pop_front();
                            if (e.d == d && e.k == k && e.kind == kind && e.cyc == cyc && e.cv == act_cv) begin
                                checks_passed++;
                            end else begin
                                $display("[TB] FAIL pulse got d%0d k%0d kind%0d cyc %0d cnt %0d, required d%0d k%0d kind%0d cyc %0d cnt %0d",
                                         d, k, kind, cyc, act_cv, e.d, e.k, e.kind, e.cyc, e.cv);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int d, input int k, input bit pressed);
        pin[d][k] = (d == 2) ? pressed : ~pressed;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic pushEv(input int d, input int k, input int kind, input int c, input int v);
        ev_t e;
        e.d = d; e.k = k; e.kind = kind; e.cyc = c; e.cv = v;
        exp_q.push_back(e);
    endtask

    task automatic checkCnt(input string name, input int d);
        checkOutput(name, int'(cv[d]), mdl[d][1] * 4 + mdl[d][0]);
    endtask

    task automatic clearModel();
        for (int d = 0; d < 3; d++) begin
            mdl[d][0] = 0;
            mdl[d][1] = 0;
        end
    endtask

    // Press at cycle s: pin sampled at s+1, press pulse at s+7, long at s+27,
    // release and short at release-drive cycle + 7. Long needs hold >= 21.
    task automatic holdKey(input int d, input int k, input int hold);
        int s;
        bit lng;
        s   = cyc;
        lng = (hold >= 21);
        applyStimulus(d, k, 1'b1);
        if (d != 1) mdl[d][k] = (mdl[d][k] + 1) % 4;
        pushEv(d, k, 0, s + 7, mdl[d][k]);
        if (lng) begin
            if (d == 1) mdl[d][k] = (mdl[d][k] + 3) % 4;
            pushEv(d, k, 3, s + 27, mdl[d][k]);
        end else if (d == 1) begin
            mdl[d][k] = (mdl[d][k] + 1) % 4;
        end
        pushEv(d, k, 1, s + hold + 7, mdl[d][k]);
        if (!lng) pushEv(d, k, 2, s + hold + 7, mdl[d][k]);
        waitCycles(hold);
        applyStimulus(d, k, 1'b0);
        waitCycles(12);
    endtask

    initial begin
        int s;
        int r;
        rst    = 1'b1;
        pin[0] = 2'b11;
        pin[1] = 2'b11;
        pin[2] = 2'b00;
        clr[0] = 2'b00;
        clr[1] = 2'b00;
        clr[2] = 2'b00;
        clearModel();

        waitCycles(3);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset_state_dut%0d", d), int'({kd[d], cv[d]}), 0);
        end
        rst = 1'b0;
        waitCycles(5);

        // 3-cycle glitch must be filtered
        applyStimulus(0, 0, 1'b1);
        waitCycles(3);
        applyStimulus(0, 0, 1'b0);
        waitCycles(12);
        checkCnt("glitch_cnt", 0);
        checkOutput("glitch_key_down", int'(kd[0]), 0);

        // five presses wrap 1,2,3,0,1
        for (int i = 0; i < 5; i++) holdKey(0, 0, 8);
        checkCnt("wrap_cnt", 0);

        // MODE 1: short, long, long with decrement wrap
        holdKey(1, 0, 10);
        checkCnt("short_cnt", 1);
        holdKey(1, 0, 30);
        checkCnt("long_cnt", 1);
        holdKey(1, 0, 30);
        checkCnt("long_wrap_cnt", 1);

        // clear wins over key0 increment; key1 increments alongside
        s = cyc;
        applyStimulus(0, 0, 1'b1);
        applyStimulus(0, 1, 1'b1);
        mdl[0][0] = 0;
        mdl[0][1] = (mdl[0][1] + 1) % 4;
        pushEv(0, 0, 0, s + 7, mdl[0][0]);
        pushEv(0, 1, 0, s + 7, mdl[0][1]);
        pushEv(0, 0, 1, s + 17, mdl[0][0]);
        pushEv(0, 0, 2, s + 17, mdl[0][0]);
        pushEv(0, 1, 1, s + 17, mdl[0][1]);
        pushEv(0, 1, 2, s + 17, mdl[0][1]);
        waitCycles(6);
        clr[0] = 2'b01;
        waitCycles(1);
        clr[0] = 2'b00;
        waitCycles(3);
        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 1, 1'b0);
        waitCycles(12);
        checkCnt("clear_priority_cnt", 0);

        // reset 12 cycles into a hold; key re-detected after reset
        s = cyc;
        applyStimulus(1, 0, 1'b1);
        pushEv(1, 0, 0, s + 7, mdl[1][0]);
        waitCycles(19);
        rst = 1'b1;
        clearModel();
        waitCycles(3);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("midhold_reset_dut%0d", d), int'({kd[d], cv[d]}), 0);
        end
        rst = 1'b0;
        r = cyc;
        pushEv(1, 0, 0, r + 7, 0);
        mdl[1][0] = 1;
        pushEv(1, 0, 1, r + 17, 1);
        pushEv(1, 0, 2, r + 17, 1);
        waitCycles(10);
        applyStimulus(1, 0, 1'b0);
        waitCycles(12);
        checkCnt("after_reset_cnt", 1);

        // active-high instance
        holdKey(2, 0, 8);
        checkCnt("polarity_cnt", 2);

        // reset with an active-high key held: nothing during reset
        rst = 1'b1;
        applyStimulus(2, 1, 1'b1);
        clearModel();
        waitCycles(4);
        checkOutput("reset_key_high", int'({kd[2], cv[2]}), 0);
        rst = 1'b0;
        r = cyc;
        mdl[2][1] = 1;
        pushEv(2, 1, 0, r + 7, 1);
        pushEv(2, 1, 1, r + 15, 1);
        pushEv(2, 1, 2, r + 15, 1);
        waitCycles(8);
        applyStimulus(2, 1, 1'b0);
        waitCycles(12);
        checkCnt("reset_key_high_cnt", 2);

        waitCycles(20);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/key_multi_ctl.md
# key_multi_ctl

Parametrised multi-key front end: synchronises, debounces and classifies N mechanical keys. Per key it produces press, release, short-press and long-press pulses and a wrapping event counter. It sits between the board key pins and LED/mode logic, and replaces single-key press counters. One clock domain, with no handshake to downstream: all event outputs are single-cycle pulses.

## Interface
- `KEY_NUM`, 4: number of keys, 1..16.
- `ACTIVE_LOW`, 1: 1 means a key reads 0 when pressed; 0 means it reads 1 when pressed.
- `DEB_CYCLES`, 20000: consecutive stable synchronised samples needed to accept a level change, ≥2.
- `LONG_CYCLES`, 1500000: cycles held, counted from acceptance of the press, before a long press is declared; must be greater than DEB_CYCLES.
- `CNT_W`, 2: width of each per-key counter.
- `MODE`, 0: 0 means the counter increments on every accepted press; 1 means it increments on a short press and decrements on a long press.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `key` input KEY_NUM: raw asynchronous key pins.
- `cnt_clr` input KEY_NUM: per-key synchronous counter clear.
- `key_down` output KEY_NUM: debounced pressed level, 1 means pressed.
- `press_pulse` output KEY_NUM: one cycle high on accepted press.
- `release_pulse` output KEY_NUM: one cycle high on accepted release.
- `short_pulse` output KEY_NUM: one cycle high on a release that had no long press.
- `long_pulse` output KEY_NUM: one cycle high when the hold reaches LONG_CYCLES.
- `cnt` output KEY_NUM*CNT_W: per-key counters; key i occupies bits [i*CNT_W +: CNT_W].

## Operation
- **Reset.** Every output is 0. Synchroniser flops reset to the released pin level, so reset produces no spurious edge. Debounce and hold counters reset to 0.
- **Polarity.** The pin is normalised to `pressed = key ^ ACTIVE_LOW`. This happens before the 2-flop synchroniser.
- **Debounce, per key.**
  - `deb_cnt` increments each cycle the synchronised sample differs from `key_down`.
  - It clears on any cycle the sample equals `key_down`.
  - When it reaches DEB_CYCLES-1 while the sample still differs, `key_down` toggles and `deb_cnt` clears.
  - A glitch shorter than DEB_CYCLES produces no event.
- **Edge pulses.**
  - `press_pulse` and `release_pulse` are registered outputs, high during the cycle after `key_down` changes.
- **Hold counter.**
  - Clears when `key_down` rises.
  - Increments each cycle while pressed and saturates at LONG_CYCLES.
  - `long_pulse` fires once per hold, when the hold counter reaches LONG_CYCLES.
  - A flag records that the long press fired.
  - On release, `short_pulse` fires in the same cycle as `release_pulse` only if the flag is clear. The flag then clears.
- **Counter arithmetic.**
  - Modulo 2^CNT_W in both directions: the maximum value plus 1 gives 0, and 0 minus 1 gives the maximum value.
  - The counter updates on the same edge that raises the triggering pulse.
- **Simultaneous events.**
  - `cnt_clr[i]` has priority over any increment or decrement in the same cycle; the result is 0.
  - Keys are fully independent; simultaneous events on several keys are all honoured.
- **Reset mid-operation.**
  - Everything clears and no pulse is emitted.
  - A key held through reset is re-detected as a new press after reset deasserts. The usual debounce latency applies.

## Timing
- Let T be the first edge at which a stable pressed level is sampled.
  - `key_down` rises at edge T+DEB_CYCLES+1.
  - `press_pulse` and the counter update (MODE 0) occur at edge T+DEB_CYCLES+2.
  - The same latency applies to release.
- `long_pulse` occurs exactly LONG_CYCLES cycles after `press_pulse`.
- Latency from `cnt_clr` to `cnt`: 1 cycle.
- The output `cnt` is a register output; the pulses are register outputs.

## Structure
- Package `key_pkg`:
  - MODE encodings `MODE_PRESS_CNT=0` and `MODE_SHORT_LONG=1`.
  - Function `clog2` for the widths of the debounce and hold counters.
- Sub-module `key_chan`, one instance per key, built with generate. It contains the synchroniser, debounce, hold counter, pulse generation and counter.
- The top level handles polarity normalisation and bus slicing only.

## Test plan
Bench parameters: KEY_NUM=2, DEB_CYCLES=4, LONG_CYCLES=20, CNT_W=2, ACTIVE_LOW=1.
- **Debounce.** Key0 low for 3 cycles then high → no pulse, `cnt`=0. Key0 held low → `press_pulse[0]` at T+6, `cnt[1:0]`=1 (MODE 0).
- **Wrap.** Five clean presses on key0 → count sequence 1, 2, 3, 0, 1.
- **Short/long, MODE 1.**
  - Hold 10 cycles then release → `short_pulse` only; `cnt` goes 0→1.
  - Hold 30 cycles → `long_pulse` 20 cycles after `press_pulse`; no `short_pulse` on release; `cnt` goes 1→0.
  - A further long press → `cnt`=3 (decrement wrap).
- **Clear priority.** Assert `cnt_clr[0]` in the cycle `press_pulse[0]` would update the counter → `cnt[1:0]`=0. Key1 pressed in the same cycle → `cnt[3:2]` increments unaffected.
- **Reset mid-hold.** Assert `rst` during a hold at cycle 12 → all outputs 0 and no `long_pulse`. Key still held after `rst` deasserts → `press_pulse` 6 cycles later.
- **Polarity.** ACTIVE_LOW=0, key driven high → `press_pulse` at T+6. Reset with key high → no pulse during reset.
